// File: rtl/rvvi_tx_arbiter.sv
// RVVI TX arbiter: merges two AXI-stream frame sources onto one MAC stream
// with frame-atomic grants, inter-frame gap and max-length truncation.
module rvvi_tx_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int IFG_CYCLES = 2,
  parameter int MAX_BEATS  = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   S0Tdata,
  input  logic [DATA_WIDTH/8-1:0] S0Tkeep,
  input  logic                    S0Tvalid,
  input  logic                    S0Tlast,
  output logic                    S0Tready,
  input  logic [DATA_WIDTH-1:0]   S1Tdata,
  input  logic [DATA_WIDTH/8-1:0] S1Tkeep,
  input  logic                    S1Tvalid,
  input  logic                    S1Tlast,
  output logic                    S1Tready,
  output logic [DATA_WIDTH-1:0]   MTdata,
  output logic [DATA_WIDTH/8-1:0] MTkeep,
  output logic                    MTvalid,
  output logic                    MTlast,
  input  logic                    MTready,
  input  logic                    Prio1,
  input  logic                    ClearErr,
  output logic [1:0]              Grant,
  output logic                    FrameDone,
  output logic                    Truncated
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN,
    GAP
  } state_t;

  localparam logic [15:0] BEAT_LAST = 16'(MAX_BEATS - 1);
  localparam logic [7:0]  GAP_LAST  =
    8'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam state_t DONE_ST = (IFG_CYCLES > 0) ? GAP : IDLE;

  state_t state;
  state_t state_nxt;

  logic [1:0]  grant_q;
  logic        last1;
  logic [15:0] beat_cnt;
  logic [7:0]  gap_cnt;
  logic        trunc_q;

  logic                    sel1;
  logic                    src_valid;
  logic                    src_last;
  logic [DATA_WIDTH-1:0]   src_data;
  logic [DATA_WIDTH/8-1:0] src_keep;
  logic                    pick1;
  logic                    at_max;
  logic                    accept;
  logic                    trunc_hit;

  assign sel1      = grant_q[1];
  assign src_valid = sel1 ? S1Tvalid : S0Tvalid;
  assign src_last  = sel1 ? S1Tlast  : S0Tlast;
  assign src_data  = sel1 ? S1Tdata  : S0Tdata;
  assign src_keep  = sel1 ? S1Tkeep  : S0Tkeep;

  // requester 1 wins alone, on priority, or when 0 was served last
  assign pick1  = S1Tvalid & (~S0Tvalid | Prio1 | ~last1);
  assign at_max = (beat_cnt == BEAT_LAST);

  assign Grant     = grant_q;
  assign Truncated = trunc_q;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state, stream muxing and handshakes
  always_comb begin
    state_nxt = state;
    MTvalid   = 1'b0;
    MTlast    = 1'b0;
    MTdata    = src_data;
    MTkeep    = src_keep;
    S0Tready  = 1'b0;
    S1Tready  = 1'b0;
    FrameDone = 1'b0;
    accept    = 1'b0;
    trunc_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (S0Tvalid | S1Tvalid) state_nxt = SEND;
      end
      SEND: begin
        MTvalid  = src_valid;
        MTlast   = src_last | at_max;
        S0Tready = ~sel1 & MTready;
        S1Tready = sel1 & MTready;
        accept   = src_valid & MTready;
        if (accept) begin
          if (src_last) begin
            FrameDone = 1'b1;
            state_nxt = DONE_ST;
          end else if (at_max) begin
            FrameDone = 1'b1;
            trunc_hit = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        S0Tready = ~sel1;
        S1Tready = sel1;
        if (src_valid & src_last) state_nxt = DONE_ST;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant, round-robin history, beat/gap counters, error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= 2'b00;
      last1    <= 1'b1;
      beat_cnt <= 16'd0;
      gap_cnt  <= 8'd0;
      trunc_q  <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == SEND) begin
        grant_q  <= pick1 ? 2'b10 : 2'b01;
        last1    <= pick1;
        beat_cnt <= 16'd0;
      end else begin
        if (accept) beat_cnt <= beat_cnt + 16'd1;
        if (state_nxt == GAP || state_nxt == IDLE)
          grant_q <= 2'b00;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
      else              gap_cnt <= 8'd0;
      if (trunc_hit)     trunc_q <= 1'b1;
      else if (ClearErr) trunc_q <= 1'b0;
    end
  end

endmodule
